// File: rtl/ccff_pkg.sv
`default_nettype none
// ============================================================================
// Package : ccff_pkg
// Shared types and defaults for the configuration-chain loader.
// Rev     : 1.0
// ============================================================================
package ccff_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MARK   = 3'd1,
      ST_WAIT_W = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_FIN    = 3'd4,
      ST_ERR    = 3'd5
   } ccff_state_e;

   localparam int         CCFF_MARKER_W = 8;
   localparam logic [7:0] CCFF_MARKER   = 8'hA5;

   function automatic int ccff_word_count(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_word_serializer.sv
`default_nettype none
// ============================================================================
// Module : ccff_word_serializer
// One host word held MSB-first, with a per-word bit counter flagging the last bit.
// Rev    : 1.0
// ============================================================================
module ccff_word_serializer #(
   parameter int WORD_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [WORD_W-1:0] data_i,
   output logic              msb_o,
   output logic              last_bit_o
);
   localparam int BW = $clog2(WORD_W + 1);

   logic [WORD_W-1:0] sr_q, sr_d;
   logic [BW-1:0]     cnt_q, cnt_d;

   // A load in the cycle of the last bit replaces the word with no bubble.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = data_i;
         cnt_d = '0;
      end else if (shift_i) begin
         sr_d = sr_q << 1;
         if (cnt_q != BW'(WORD_W)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign msb_o      = sr_q[WORD_W-1];
   assign last_bit_o = (cnt_q == BW'(WORD_W - 1));

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module : ccff_chain_loader
// Serialises host words onto an I/O-tile config chain, keeping I/O isolated
// until a complete load. Option macro: CCFF_LOOPBACK_CHECK_EN (marker loopback).
// Rev    : 1.0
// ============================================================================
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int                  CHAIN_LEN = 64,
   parameter int                  WORD_W    = 8,
   parameter int                  MARKER_W  = CCFF_MARKER_W,
   parameter logic [MARKER_W-1:0] MARKER    = CCFF_MARKER
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              cfg_shift_en,
   output logic              IO_ISOL_N,
   output logic              busy,
   output logic              done,
   output logic              error
);
   localparam int CW = $clog2(CHAIN_LEN + MARKER_W + 1);

   ccff_state_e   state_q, state_d;
   logic [CW-1:0] dcnt_q, dcnt_d;
   logic          busy_q, fin_q;
   logic          ser_load, ser_shift, ser_msb, ser_last;
   logic          data_last, fail, begin_load;

   assign data_last = (dcnt_q == CW'(CHAIN_LEN - 1));

`ifdef CCFF_LOOPBACK_CHECK_EN
   localparam ccff_state_e FIRST_ST = ST_MARK;

   logic [CW-1:0]       ecnt_q;
   logic                mism_q, shifted_q, error_q;
   logic                cmp_en, cmp_bad, mark_bit;
   logic [MARKER_W-1:0] mark_vec, exp_vec;

   // ecnt_q = shift edges so far; marker bit i reaches the tail after edge i+CHAIN_LEN.
   assign mark_vec = MARKER << ecnt_q;
   assign mark_bit = mark_vec[MARKER_W-1];
   assign exp_vec  = MARKER << (ecnt_q - CW'(CHAIN_LEN));
   assign cmp_en   = shifted_q && (ecnt_q >= CW'(CHAIN_LEN))
                     && (ecnt_q < CW'(CHAIN_LEN + MARKER_W));
   assign cmp_bad  = cmp_en && (ccff_tail != exp_vec[MARKER_W-1]);
   assign fail     = mism_q | cmp_bad;

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         ecnt_q    <= '0;
         mism_q    <= 1'b0;
         shifted_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         shifted_q <= cfg_shift_en;
         error_q   <= (state_d == ST_ERR);
         if (begin_load) begin
            ecnt_q <= '0;
            mism_q <= 1'b0;
         end else begin
            if (cfg_shift_en && (ecnt_q != CW'(CHAIN_LEN + MARKER_W))) begin
               ecnt_q <= ecnt_q + 1'b1;
            end
            if (cmp_bad) begin
               mism_q <= 1'b1;
            end
         end
      end
   end

   assign error = error_q;
`else
   localparam ccff_state_e FIRST_ST = ST_WAIT_W;

   logic unused_ok;
   assign unused_ok = ^{ccff_tail, MARKER};
   assign fail      = 1'b0;
   assign error     = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      dcnt_d       = dcnt_q;
      begin_load   = 1'b0;
      word_ready   = 1'b0;
      cfg_shift_en = 1'b0;
      ccff_head    = 1'b0;
      ser_load     = 1'b0;
      ser_shift    = 1'b0;
      case (state_q)
         ST_IDLE, ST_FIN, ST_ERR: begin
            if (start) begin
               begin_load = 1'b1;
               dcnt_d     = '0;
               state_d    = FIRST_ST;
            end
         end
`ifdef CCFF_LOOPBACK_CHECK_EN
         ST_MARK: begin
            cfg_shift_en = 1'b1;
            ccff_head    = mark_bit;
            if (ecnt_q == CW'(MARKER_W - 1)) begin
               state_d = ST_WAIT_W;
            end
         end
`endif
         ST_WAIT_W: begin
            word_ready = 1'b1;
            if (word_valid) begin
               ser_load = 1'b1;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            cfg_shift_en = 1'b1;
            ccff_head    = ser_msb;
            ser_shift    = 1'b1;
            if (dcnt_q != CW'(CHAIN_LEN)) begin
               dcnt_d = dcnt_q + 1'b1;
            end
            // Reaching CHAIN_LEN ends the load even mid-word, dropping the excess bits.
            if (data_last) begin
               state_d = fail ? ST_ERR : ST_FIN;
            end else if (ser_last) begin
               word_ready = 1'b1;
               if (word_valid) begin
                  ser_load = 1'b1;
               end else begin
                  state_d = ST_WAIT_W;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q <= ST_IDLE;
         dcnt_q  <= '0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         busy_q  <= (state_d == ST_MARK) || (state_d == ST_WAIT_W) || (state_d == ST_SHIFT);
         fin_q   <= (state_d == ST_FIN);
      end
   end

   // done and I/O release both mean "sitting in FIN", so they share one flop.
   assign busy      = busy_q;
   assign done      = fin_q;
   assign IO_ISOL_N = fin_q;

   ccff_word_serializer #(
      .WORD_W (WORD_W)
   ) u_ser (
      .clk_i      (prog_clk),
      .rst_ni     (prog_reset_n),
      .load_i     (ser_load),
      .shift_i    (ser_shift),
      .data_i     (word_data),
      .msb_o      (ser_msb),
      .last_bit_o (ser_last)
   );

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_ccff_chain_loader
// Random-stimulus bench with a 20-flop chain model; follows CCFF_LOOPBACK_CHECK_EN.
// Rev    : 1.0
// ============================================================================
module tb_ccff_chain_loader;
   localparam int CHAIN_LEN = 20;
   localparam int WORD_W    = 8;
   localparam int MARKER_W  = 8;
`ifdef CCFF_LOOPBACK_CHECK_EN
   localparam bit LB_EN = 1'b1;
`else
   localparam bit LB_EN = 1'b0;
`endif

   logic              prog_clk;
   logic              prog_reset_n;
   logic              start;
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;
   logic              ccff_head;
   logic              ccff_tail;
   logic              cfg_shift_en;
   logic              IO_ISOL_N;
   logic              busy;
   logic              done;
   logic              error;

   logic [CHAIN_LEN-1:0] chain = '0;
   bit                   broken;
   int                   n_cmp = 0;
   int                   n_bad = 0;

   ccff_chain_loader #(
      .CHAIN_LEN (CHAIN_LEN),
      .WORD_W    (WORD_W),
      .MARKER_W  (MARKER_W),
      .MARKER    (8'hA5)
   ) dut (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .start        (start),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .ccff_head    (ccff_head),
      .ccff_tail    (ccff_tail),
      .cfg_shift_en (cfg_shift_en),
      .IO_ISOL_N    (IO_ISOL_N),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // External chain: plain shift register, first bit shifted ends up at the tail.
   always @(posedge prog_clk) begin
      if (cfg_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   end
   assign ccff_tail = broken ? 1'b0 : chain[CHAIN_LEN-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int fix_stall, input int rnd_stall, input bit brk,
                           input bit mid_start, input int rst_at);
      logic [7:0]  words [3];
      logic [23:0] stream;
      int idx, stall, nshift, runs, head_bad, cyc, exp_total, mid_cyc;
      bit hs_prev, prev_sh, exp_err;
      words     = '{w0, w1, w2};
      stream    = {w0, w1, w2};
      broken    = brk;
      exp_err   = LB_EN && brk;
      exp_total = CHAIN_LEN + (LB_EN ? MARKER_W : 0);
      idx = 0; stall = 0; nshift = 0; runs = 0; head_bad = 0; cyc = 0;
      hs_prev = 1'b0; prev_sh = 1'b0;
      mid_cyc = int'($urandom_range(3, 15));

      @(negedge prog_clk);
      start      = 1'b1;
      word_valid = 1'b1;
      word_data  = w0;
      @(negedge prog_clk);
      start = 1'b0;
      check("post_start", 32'({busy, done, error, IO_ISOL_N}), 32'b1000);

      while (1) begin
         if (hs_prev) begin
            idx++;
            stall = fix_stall + int'($urandom_range(0, rnd_stall));
         end
         if (idx < 3 && stall == 0) begin
            word_valid = 1'b1;
            word_data  = words[idx];
         end else begin
            word_valid = 1'b0;
            if (stall > 0) stall--;
         end
         hs_prev = word_valid && word_ready;
         start   = mid_start && (cyc == mid_cyc);
         if (cfg_shift_en) begin
            nshift++;
            if (!prev_sh) runs++;
         end else if (ccff_head) begin
            head_bad++;
         end
         prev_sh = cfg_shift_en;
         if (rst_at != 0 && nshift == rst_at) begin
            #2 prog_reset_n = 1'b0;
            #1;
            check("async_reset", 32'({busy, done, error, IO_ISOL_N, word_ready, cfg_shift_en, ccff_head}), 32'd0);
            @(negedge prog_clk);
            prog_reset_n = 1'b1;
            start        = 1'b0;
            word_valid   = 1'b0;
            return;
         end
         if (nshift == exp_total || cyc == 400) break;
         cyc++;
         @(negedge prog_clk);
      end
      start      = 1'b0;
      word_valid = 1'b0;
      check("shift_count", 32'(nshift), 32'(exp_total));
      check("head_zero_idle", 32'(head_bad), 32'd0);
      if (fix_stall == 0 && rnd_stall == 0) check("shift_runs", 32'(runs), LB_EN ? 32'd2 : 32'd1);
      @(negedge prog_clk);
      check("end_flags", 32'({busy, done, error, IO_ISOL_N}), exp_err ? 32'b0010 : 32'b0101);
      check("end_quiet", 32'({word_ready, cfg_shift_en, ccff_head}), 32'd0);
      check("chain", 32'(chain), 32'(stream[23:4]));
   endtask

   initial begin
      prog_reset_n = 1'b0;
      start        = 1'b0;
      word_valid   = 1'b0;
      word_data    = '0;
      broken       = 1'b0;
      repeat (2) @(negedge prog_clk);
      check("reset_outs", 32'({busy, done, error, IO_ISOL_N, word_ready, cfg_shift_en, ccff_head}), 32'd0);
      prog_reset_n = 1'b1;

      begin
         int bad = 0;
         word_valid = 1'b1;
         word_data  = 8'h77;
         repeat (6) begin
            @(negedge prog_clk);
            if (word_ready || cfg_shift_en || busy) bad++;
         end
         word_valid = 1'b0;
         check("idle_no_accept", 32'(bad), 32'd0);
      end

      run_load(8'hC3, 8'h5A, 8'hF0, 0, 0, 1'b0, 1'b0, 0);
      run_load(8'hC3, 8'h5A, 8'hF0, 5, 0, 1'b0, 1'b0, 0);
      run_load(8'h96, 8'h3C, 8'h81, 0, 0, 1'b0, 1'b1, 0);
      run_load(8'hE7, 8'h18, 8'h42, 0, 0, 1'b1, 1'b0, 0);
      run_load(8'h5A, 8'hA5, 8'h0F, 0, 1, 1'b0, 1'b0, 0);
      run_load(8'h3C, 8'h96, 8'h0F, 0, 0, 1'b0, 1'b0, 10);
      run_load(8'h3C, 8'h96, 8'h0F, 0, 0, 1'b0, 1'b0, 0);
      for (int r = 0; r < 6; r++) begin
         run_load(8'($urandom), 8'($urandom), 8'($urandom), 0, 3,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
